// File: rtl/mips_mc_datapath.sv
// Multicycle MIPS datapath: PC, IR, MDR, A/B, ALUOut, 32x32 register file and ALU,
// steered each cycle by the control word from the multicycle controller.
module mips_mc_datapath #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pcen,
   input  logic [1:0]  pcsrc,
   input  logic        irwrite,
   input  logic        lord,
   input  logic        alusrca,
   input  logic [1:0]  alusrcb,
   input  logic [2:0]  alucontrol,
   input  logic        regdst,
   input  logic        memtoreg,
   input  logic        regwrite,
   input  logic [31:0] readdata,
   output logic [31:0] adr,
   output logic [31:0] writedata,
   output logic [5:0]  op,
   output logic [5:0]  funct,
   output logic        zero
);

   logic [31:0] pc, instr, data, a, b, aluout;
   logic [31:0] regs [32];
   logic [31:0] rd1, rd2, wd3, signimm, jaddr;
   logic [31:0] srca, srcb, aluresult, pcnext;
   logic [4:0]  rs, rt, rd, wa;

   assign rs      = instr[25:21];
   assign rt      = instr[20:16];
   assign rd      = instr[15:11];
   assign wa      = regdst ? rd : rt;
   assign wd3     = memtoreg ? data : aluout;
   assign signimm = {{16{instr[15]}}, instr[15:0]};
   assign jaddr   = {pc[31:28], instr[25:0], 2'b00};

   // Register 0 is hardwired to zero on the read side as well as blocked on write.
   assign rd1 = (rs == 5'd0) ? 32'd0 : regs[rs];
   assign rd2 = (rt == 5'd0) ? 32'd0 : regs[rt];

   assign srca = alusrca ? a : pc;

   always_comb begin
      srcb = b;
      case (alusrcb)
         2'b00:   srcb = b;
         2'b01:   srcb = 32'd4;
         2'b10:   srcb = signimm;
         default: srcb = {signimm[29:0], 2'b00};
      endcase
   end

   always_comb begin
      aluresult = 32'd0;
      case (alucontrol)
         3'b000:  aluresult = srca & srcb;
         3'b001:  aluresult = srca | srcb;
         3'b010:  aluresult = srca + srcb;
         3'b110:  aluresult = srca - srcb;
         3'b111:  aluresult = ($signed(srca) < $signed(srcb)) ? 32'd1 : 32'd0;
         default: aluresult = 32'd0;
      endcase
   end

   always_comb begin
      pcnext = pc;
      case (pcsrc)
         2'b00:   pcnext = aluresult;
         2'b01:   pcnext = aluout;
         2'b10:   pcnext = jaddr;
         default: pcnext = pc;
      endcase
   end

   assign zero      = (aluresult == 32'd0);
   assign adr       = lord ? aluout : pc;
   assign writedata = b;
   assign op        = instr[31:26];
   assign funct     = instr[5:0];

   // Architectural and inter-cycle registers; Data, A, B and ALUOut refresh every cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc     <= RESET_PC;
         instr  <= 32'd0;
         data   <= 32'd0;
         a      <= 32'd0;
         b      <= 32'd0;
         aluout <= 32'd0;
      end else begin
         if (pcen)
            pc <= pcnext;
         if (irwrite)
            instr <= readdata;
         data   <= readdata;
         a      <= rd1;
         b      <= rd2;
         aluout <= aluresult;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++)
            regs[i] <= 32'd0;
      end else if (regwrite && (wa != 5'd0)) begin
         regs[wa] <= wd3;
      end
   end

endmodule

// File: tb/tb_mips_mc_datapath.sv
// Self-checking bench for mips_mc_datapath: directed instruction sequences followed by
// random control words, all checked against a behavioural model of the datapath.
module tb_mips_mc_datapath;

   localparam logic [31:0] RESET_PC = 32'h0000_0040;

   logic        clk = 1'b0;
   logic        reset;
   logic        pcen, irwrite, lord, alusrca, regdst, memtoreg, regwrite;
   logic [1:0]  pcsrc, alusrcb;
   logic [2:0]  alucontrol;
   logic [31:0] readdata, adr, writedata;
   logic [5:0]  op, funct;
   logic        zero;

   mips_mc_datapath #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset(reset), .pcen(pcen), .pcsrc(pcsrc), .irwrite(irwrite),
      .lord(lord), .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol),
      .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .readdata(readdata),
      .adr(adr), .writedata(writedata), .op(op), .funct(funct), .zero(zero)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pcen;
      logic [1:0] pcsrc;
      logic       irwrite;
      logic       lord;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [2:0] alucontrol;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
   } ctl_t;

   int checks = 0;
   int passed = 0;

   // Reference machine state
   logic [31:0] mpc, minstr, mdata, ma, mb, maluout;
   logic [31:0] mregs [32];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed === expected)
         passed++;
      else
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
   endtask

   function automatic ctl_t mkCtl(input logic p, input logic [1:0] ps, input logic ir, input logic ld,
                                  input logic sa, input logic [1:0] sb, input logic [2:0] ac,
                                  input logic rdst, input logic m2r, input logic rw);
      return {p, ps, ir, ld, sa, sb, ac, rdst, m2r, rw};
   endfunction

   function automatic logic [31:0] readReg(input logic [4:0] idx);
      return (idx == 5'd0) ? 32'd0 : mregs[idx];
   endfunction

   function automatic logic [31:0] modelAlu(input ctl_t c);
      logic [31:0] x, y, imm;
      imm = {{16{minstr[15]}}, minstr[15:0]};
      x = c.alusrca ? ma : mpc;
      case (c.alusrcb)
         2'd0:    y = mb;
         2'd1:    y = 32'd4;
         2'd2:    y = imm;
         default: y = imm * 4;
      endcase
      case (c.alucontrol)
         3'd0:    return x & y;
         3'd1:    return x | y;
         3'd2:    return x + y;
         3'd6:    return x - y;
         3'd7:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic modelReset();
      mpc = RESET_PC;
      minstr = 0; mdata = 0; ma = 0; mb = 0; maluout = 0;
      for (int i = 0; i < 32; i++) mregs[i] = 0;
   endtask

   task automatic modelAdvance(input ctl_t c, input logic [31:0] rdata);
      logic [31:0] res, npc, na, nb, wval;
      logic [4:0]  wreg;
      res = modelAlu(c);
      npc = mpc;
      if (c.pcen) begin
         case (c.pcsrc)
            2'd0:    npc = res;
            2'd1:    npc = maluout;
            2'd2:    npc = {mpc[31:28], minstr[25:0], 2'b00};
            default: npc = mpc;
         endcase
      end
      na   = readReg(minstr[25:21]);
      nb   = readReg(minstr[20:16]);
      wreg = c.regdst ? minstr[15:11] : minstr[20:16];
      wval = c.memtoreg ? mdata : maluout;
      if (c.regwrite && wreg != 5'd0) mregs[wreg] = wval;
      if (c.irwrite) minstr = rdata;
      mpc = npc; mdata = rdata; ma = na; mb = nb; maluout = res;
   endtask

   task automatic setInputs(input ctl_t c, input logic [31:0] rdata);
      pcen = c.pcen; pcsrc = c.pcsrc; irwrite = c.irwrite; lord = c.lord;
      alusrca = c.alusrca; alusrcb = c.alusrcb; alucontrol = c.alucontrol;
      regdst = c.regdst; memtoreg = c.memtoreg; regwrite = c.regwrite;
      readdata = rdata;
   endtask

   // One clock cycle: drive, compare combinational outputs mid-cycle, then step the model.
   task automatic applyStimulus(input ctl_t c, input logic [31:0] rdata);
      setInputs(c, rdata);
      @(negedge clk);
      checkOutput("adr", adr, c.lord ? maluout : mpc);
      checkOutput("writedata", writedata, mb);
      checkOutput("op", {26'd0, op}, {26'd0, minstr[31:26]});
      checkOutput("funct", {26'd0, funct}, {26'd0, minstr[5:0]});
      checkOutput("zero", {31'd0, zero}, {31'd0, modelAlu(c) == 32'd0});
      @(posedge clk);
      modelAdvance(c, rdata);
      #1;
   endtask

   ctl_t fetchC, idleC, decodeC, memadrC, memrdC, wbmemC, wbaluC, beqC, jrC, jmpC, sltC, holdC, orC;

   task automatic loadReg(input logic [4:0] idx, input logic [31:0] val);
      applyStimulus(fetchC, {6'h23, 5'd0, idx, 16'h0000});
      applyStimulus(idleC, val);
      applyStimulus(wbmemC, val);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] r;
      fetchC  = mkCtl(1, 2'd0, 1, 0, 0, 2'd1, 3'd2, 0, 0, 0);
      idleC   = mkCtl(0, 2'd0, 0, 0, 0, 2'd0, 3'd2, 0, 0, 0);
      decodeC = mkCtl(0, 2'd0, 0, 0, 0, 2'd3, 3'd2, 0, 0, 0);
      memadrC = mkCtl(0, 2'd0, 0, 0, 1, 2'd2, 3'd2, 0, 0, 0);
      memrdC  = mkCtl(0, 2'd0, 0, 1, 0, 2'd0, 3'd2, 0, 0, 0);
      wbmemC  = mkCtl(0, 2'd0, 0, 0, 0, 2'd0, 3'd2, 0, 1, 1);
      wbaluC  = mkCtl(0, 2'd0, 0, 0, 0, 2'd0, 3'd2, 0, 0, 1);
      beqC    = mkCtl(1, 2'd1, 0, 0, 1, 2'd0, 3'd6, 0, 0, 0);
      jrC     = mkCtl(1, 2'd0, 0, 0, 1, 2'd0, 3'd2, 0, 0, 0);
      jmpC    = mkCtl(1, 2'd2, 0, 0, 0, 2'd0, 3'd2, 0, 0, 0);
      sltC    = mkCtl(0, 2'd0, 0, 0, 1, 2'd0, 3'd7, 0, 0, 0);
      holdC   = mkCtl(1, 2'd3, 0, 0, 0, 2'd0, 3'd2, 0, 0, 0);
      orC     = mkCtl(0, 2'd0, 0, 0, 1, 2'd0, 3'd1, 0, 0, 0);

      reset = 1'b1;
      setInputs(idleC, 32'd0);
      modelReset();
      #2;
      checkOutput("reset_adr", adr, RESET_PC);
      checkOutput("reset_op", {26'd0, op}, 32'd0);
      checkOutput("reset_funct", {26'd0, funct}, 32'd0);
      checkOutput("reset_writedata", writedata, 32'd0);
      checkOutput("reset_zero", {31'd0, zero}, {31'd0, RESET_PC == 32'd0});
      @(posedge clk);
      #2;
      reset = 1'b0;

      // lw $8, 4($0)
      applyStimulus(fetchC, 32'h8C08_0004);
      checkOutput("fetch_op", {26'd0, op}, 32'h23);
      checkOutput("fetch_pc", adr, RESET_PC + 32'd4);
      applyStimulus(decodeC, 32'd0);
      applyStimulus(memadrC, 32'd0);
      setInputs(memrdC, 32'hDEAD_BEEF);
      #1;
      checkOutput("lw_adr", adr, 32'd4);
      applyStimulus(memrdC, 32'hDEAD_BEEF);
      applyStimulus(wbmemC, 32'hDEAD_BEEF);
      applyStimulus(idleC, 32'd0);
      checkOutput("lw_b", writedata, 32'hDEAD_BEEF);

      // beq $9, $9, -1 with $9 = 5, fetched from 0x48
      loadReg(5'd9, 32'd5);
      applyStimulus(fetchC, {6'h04, 5'd9, 5'd9, 16'hFFFF});
      applyStimulus(decodeC, 32'd0);
      setInputs(beqC, 32'd0);
      #1;
      checkOutput("beq_zero", {31'd0, zero}, 32'd1);
      applyStimulus(beqC, 32'd0);
      checkOutput("beq_pc", adr, 32'h0000_0048);

      // PC <- 0x1000_0000 through a register, then j 0x40
      loadReg(5'd10, 32'h1000_0000);
      applyStimulus(fetchC, {6'h00, 5'd10, 5'd0, 16'h0008});
      applyStimulus(decodeC, 32'd0);
      applyStimulus(jrC, 32'd0);
      applyStimulus(fetchC, 32'h0800_0010);
      checkOutput("jump_prepc", adr, 32'h1000_0004);
      applyStimulus(jmpC, 32'd0);
      checkOutput("jump_pc", adr, 32'h1000_0040);

      // Attempted write of 0x1234 into $0
      applyStimulus(fetchC, {6'h08, 5'd0, 5'd0, 16'h1234});
      applyStimulus(decodeC, 32'd0);
      applyStimulus(memadrC, 32'd0);
      applyStimulus(wbaluC, 32'd0);
      applyStimulus(idleC, 32'd0);
      applyStimulus(idleC, 32'd0);
      checkOutput("r0_reads_zero", writedata, 32'd0);

      // slt $13, $11, $12 with -1 < 1
      loadReg(5'd11, 32'hFFFF_FFFF);
      loadReg(5'd12, 32'd1);
      applyStimulus(fetchC, {6'h00, 5'd11, 5'd12, 5'd13, 5'd0, 6'h2A});
      checkOutput("slt_funct", {26'd0, funct}, 32'h2A);
      applyStimulus(decodeC, 32'd0);
      applyStimulus(sltC, 32'd0);
      setInputs(memrdC, 32'd0);
      #1;
      checkOutput("slt_result", adr, 32'd1);
      applyStimulus(memrdC, 32'd0);

      applyStimulus(holdC, 32'd0);
      checkOutput("hold_pc", adr, 32'h1000_0050);

      // Asynchronous reset in the middle of a cycle
      setInputs(idleC, 32'd0);
      #1;
      reset = 1'b1;
      #1;
      modelReset();
      checkOutput("midreset_adr", adr, 32'h0000_0040);
      checkOutput("midreset_op", {26'd0, op}, 32'd0);
      checkOutput("midreset_funct", {26'd0, funct}, 32'd0);
      checkOutput("midreset_writedata", writedata, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("midreset_hold_adr", adr, 32'h0000_0040);
      reset = 1'b0;

      applyStimulus(fetchC, {6'h00, 5'd8, 5'd12, 16'h0000});
      applyStimulus(decodeC, 32'd0);
      setInputs(orC, 32'd0);
      #1;
      checkOutput("postreset_b", writedata, 32'd0);
      checkOutput("postreset_a_or_b_zero", {31'd0, zero}, 32'd1);
      applyStimulus(orC, 32'd0);

      for (int i = 0; i < 400; i++) begin
         ctl_t c;
         r = $urandom;
         c = r[13:0];
         applyStimulus(c, $urandom);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/mips_mc_datapath.md
# mips_mc_datapath

Multicycle MIPS datapath that executes the per-cycle control word issued by the team's multicycle controller. It holds the PC, instruction, data, A/B and ALUOut registers, a 32x32 register file and the ALU. It drives the unified memory address and write data, and returns op, funct and zero to the controller.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- pcen  in  1  PC write enable (already branch&zero | pcwrite)
- pcsrc  in  2  next-PC select
- irwrite  in  1  instruction register load
- lord  in  1  address select: 0 = PC, 1 = ALUOut
- alusrca  in  1  SrcA select: 0 = PC, 1 = A
- alusrcb  in  2  SrcB select
- alucontrol  in  3  ALU function
- regdst  in  1  write register select: 0 = rt, 1 = rd
- memtoreg  in  1  write data select: 0 = ALUOut, 1 = Data
- regwrite  in  1  register file write enable
- readdata  in  32  memory read data
- adr  out  32  memory address
- writedata  out  32  memory write data (= B register)
- op  out  6  instr[31:26]
- funct  out  6  instr[5:0]
- zero  out  1  ALU result == 0

## Operation
- State registers:
  - PC: loads when pcen.
  - Instr: loads readdata when irwrite.
  - Data: loads readdata every cycle.
  - A, B: load register file rd1 and rd2 every cycle.
  - ALUOut: loads ALU result every cycle.
- Register file:
  - rs = instr[25:21], rt = instr[20:16], rd = instr[15:11].
  - Read ports are combinational.
  - Write occurs on the clock edge when regwrite=1 and the write register ≠ 0.
  - Register 0 always reads 0.
  - No write-to-read bypass.
- signimm = sign-extended instr[15:0]. jaddr = {PC[31:28], instr[25:0], 2'b00}.
- SrcB select: 00 = B, 01 = 32'd4, 10 = signimm, 11 = signimm<<2.
- Next-PC select: 00 = ALU result (combinational), 01 = ALUOut, 10 = jaddr, 11 = current PC (hold).
- ALU functions, 32-bit with no overflow detection:
  - 000 AND, 001 OR, 010 ADD, 110 SUB.
  - 111 SLT: signed compare, result 32'd1 or 32'd0.
  - 011, 100, 101: result 0.
- Outputs:
  - adr = lord ? ALUOut : PC (combinational).
  - op, funct come straight from the instruction register.
  - zero is combinational from the current ALU result.

## Timing
- Reset (asynchronous):
  - PC = RESET_PC.
  - Instr, Data, A, B, ALUOut = 0.
  - All 32 registers = 0.
- Outputs immediately after reset: adr = RESET_PC (lord=0), writedata = 0, op = 0, funct = 0.
- zero follows the inputs combinationally; with alusrca=0, alusrcb=00 and alucontrol=010 it equals (RESET_PC == 0).
- All loads happen on the rising edge of clk.
- Values are visible the cycle after the enable:
  - Instr and op/funct one cycle after irwrite.
  - Fetched word reaches Data one cycle after the address is presented; a register write through memtoreg uses Data in the following cycle.
  - A/B reflect a register write no earlier than one cycle after the write edge.
- Fetch cycle (lord=0, irwrite=1, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, pcen=1):
  - Instr ← mem[PC].
  - PC ← PC+4 in the same edge.
- Simultaneous events:
  - Simultaneous pcen and irwrite use the pre-edge PC for both the address and PC+4.
  - Simultaneous regwrite and A/B load: A/B capture the old register value.
- Reset asserted mid-instruction clears state immediately, regardless of clk.
- After reset deassertion, the first edge behaves as a normal cycle.

## Test plan
- Reset:
  - Assert reset mid-run with RESET_PC=32'h0000_0040.
  - Required: adr = 0x40, op = 0, funct = 0, writedata = 0 asynchronously.
  - Reading any register afterwards returns 0.
- Fetch:
  - readdata = 0x8C08_0004 with the fetch control word, one edge.
  - Required: op = 6'h23, PC = RESET_PC+4.
- lw sequence:
  - $0 base, imm 4; ALUOut = 4; lord=1 presents adr=4; readdata = 0xDEAD_BEEF.
  - Then memtoreg=1, regdst=0, regwrite=1.
  - Required: $8 = 0xDEAD_BEEF; subsequent B = 0xDEAD_BEEF when rt=8.
- beq taken:
  - A = B = 5 with alucontrol=110, pcsrc=01, pcen=1.
  - ALUOut holds PC+4+(imm<<2) from the prior cycle with imm = -1.
  - Required: zero = 1 and PC = old PC+4-4.
- Jump:
  - instr = 0x0800_0010, PC = 0x1000_0004, pcsrc=10, pcen=1.
  - Required: PC = 0x1000_0040.
- r0 / slt / hold:
  - Write 0x1234 to register 0: it still reads 0.
  - SLT of A = 0xFFFF_FFFF, B = 1 gives 1.
  - pcsrc=11 with pcen=1 leaves PC unchanged.
